// File: rtl/gb_pkg.sv
// Shared constants and types for the Game Boy style bus blocks.
// The echo-region page fold lives here so the bus decode can reuse it.
package gb_pkg;

  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam logic [7:0]  ECHO_FOLD_MASK = 8'hDF;

  typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} dma_state_t;

  // Pages E0..FF mirror WRAM at C0..DF.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page >= 8'hE0) ? (page & ECHO_FOLD_MASK) : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from a source page into OAM, one byte per
// M-cycle, with a one-cycle read-to-write pipeline.
module oam_dma
  import gb_pkg::*;
#(
  parameter int unsigned LEN    = 160,
  parameter int unsigned OAM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              reg_write,
  input  logic [7:0]        reg_in,
  output logic [7:0]        reg_out,
  output logic [15:0]       src_addr,
  output logic              src_rd,
  input  logic [7:0]        src_data,
  output logic [OAM_AW-1:0] oam_addr,
  output logic [7:0]        oam_wdata,
  output logic              oam_we,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(LEN + 1);
  localparam logic [IdxW-1:0] IdxLen  = IdxW'(LEN);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(LEN - 1);

  dma_state_t        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        page_q, page_d;
  logic [7:0]        reg_q, reg_d;
  logic [15:0]       addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [OAM_AW-1:0] oaddr_q, oaddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;

  // rd_q doubles as the "read outstanding" flag: src_data for it is valid now.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    reg_d   = reg_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    oaddr_d = oaddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;

    if (reg_write) begin
      // Restart drops any outstanding read without writing it.
      reg_d   = reg_in;
      page_d  = fold_page(reg_in);
      state_d = START;
      idx_d   = '0;
      busy_d  = 1'b1;
      rd_d    = 1'b0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: ;
        START: state_d = XFER;
        XFER: begin
          if (rd_q) begin
            we_d    = 1'b1;
            wdata_d = src_data;
            oaddr_d = OAM_AW'(idx_q - IdxW'(1));
          end
          if (idx_q < IdxLen) begin
            addr_d = {page_q, 8'(idx_q)};
            rd_d   = 1'b1;
            idx_d  = idx_q + IdxW'(1);
            if (idx_q == IdxLast) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (rd_q) begin
            we_d    = 1'b1;
            wdata_d = src_data;
            oaddr_d = OAM_AW'(idx_q - IdxW'(1));
          end
          rd_d    = 1'b0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      page_q  <= 8'h00;
      reg_q   <= 8'h00;
      addr_q  <= 16'h0000;
      rd_q    <= 1'b0;
      oaddr_q <= '0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      reg_q   <= reg_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      oaddr_q <= oaddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  assign reg_out   = reg_q;
  assign src_addr  = addr_q;
  assign src_rd    = rd_q;
  assign oam_addr  = oaddr_q;
  assign oam_wdata = wdata_q;
  assign oam_we    = we_q;
  assign busy      = busy_q;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine. Copies LEN bytes from a CPU-bus source page into sprite attribute memory (OAM), which the PPU scans.
- A CPU write to register FF46 starts a transfer. The engine then owns the source read port, one byte per M-cycle, and drives OAM writes.
- Sits between the top-level bus decode (upstream) and the PPU's OAM (downstream). Raises busy so the top-level decode restricts the CPU to HRAM.

Parameters:
- LEN, 160: bytes per transfer (OAM entries 0..LEN-1).
- OAM_AW, 8: OAM address width.

Ports:
- clk  in  1  system clock (4x CPU clock).
- rst  in  1  asynchronous active-low reset.
- ce  in  1  M-cycle enable, one clk pulse per CPU M-cycle; all transfer stepping happens on clk edges where ce=1.
- reg_write  in  1  CPU write strobe, FF46 already decoded.
- reg_in  in  8  source page byte written by the CPU.
- reg_out  out  8  last written page, readback.
- src_addr  out  16  source read address.
- src_rd  out  1  source read request.
- src_data  in  8  source read data, valid at the ce edge after the request.
- oam_addr  out  OAM_AW  OAM write index.
- oam_wdata  out  8  OAM write data.
- oam_we  out  1  OAM write strobe, one clk cycle wide.
- busy  out  1  transfer in progress; the bus locks the CPU out of non-HRAM space.

Behaviour:
- Reset (async, rst=0) forces: state=IDLE, reg_out=8'h00, src_addr=0, src_rd=0, oam_addr=0, oam_wdata=0, oam_we=0, busy=0.
  - Reset mid-transfer aborts immediately. No further oam_we is issued.
- All outputs are registered.
- States are IDLE, START, XFER, DRAIN.
- reg_write=1 on any clk edge:
  - reg_out <= reg_in.
  - Effective page <= (reg_in >= 8'hE0) ? reg_in & 8'hDF : reg_in. This folds the echo region onto WRAM.
  - State <= START, idx <= 0, busy <= 1.
  - This applies from any state, including mid-transfer (restart). A pending read result is discarded on restart: no oam_we for it.
- START: the next ce edge moves to XFER. This gives one M-cycle startup delay.
- XFER, at each ce edge:
  - If a read was outstanding, latch src_data into oam_wdata, set oam_addr=idx-1 and pulse oam_we for one clk.
  - If idx<LEN, drive src_addr={page, idx}, src_rd=1, idx<=idx+1.
  - After the read of idx=LEN-1 is issued, go to DRAIN.
- DRAIN: the next ce edge performs the final write (oam_addr=LEN-1), drops src_rd, and goes to IDLE with busy<=0.
- Totals per transfer:
  - exactly LEN oam_we pulses, with strictly increasing oam_addr 0..LEN-1;
  - busy high for 1+LEN+1 ce edges after the write edge.
- src_rd is held for the whole M-cycle (until the next ce edge). src_addr is stable while src_rd=1.
- reg_write coincident with a ce edge: the restart wins. No read is issued on that edge, and any outstanding data is dropped.
- ce=0 stalls everything except reg capture. oam_we is never asserted on a clk without a preceding ce edge.
- idx width is ceil(log2(LEN+1)). oam_addr never exceeds LEN-1.

Decomposition:
- Shared package gb_pkg holds:
  - constants DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, ECHO_FOLD_MASK=8'hDF;
  - typedef enum dma_state_t {IDLE, START, XFER, DRAIN}.
- No sub-module. The counter and pipeline register are small enough to live inline.

Test Plan:
- Reset check: rst=0 then release. All outputs are 0; busy=0; reg_out=8'h00.
- Basic transfer: ce every 4th clk; write reg_in=8'hC1; source model returns low address byte.
  - 160 oam_we pulses: oam_addr 0..159, oam_wdata 0..159.
  - src_addr runs C100..C19F.
  - busy high for 162 ce edges.
  - reg_out=8'hC1.
- Echo fold: write reg_in=8'hE3. src_addr starts at 16'hC300.
- Restart: write 8'h80 at ce edge 50, then 8'hC0 mid-transfer.
  - oam_addr restarts at 0 after the second startup delay.
  - No write uses a stale byte from page 80.
  - Total writes after the restart = 160.
- ce stall: hold ce=0 for 20 clks mid-transfer. Outputs are frozen and there is no extra oam_we.
- Async reset mid-transfer at idx=37: busy=0 and oam_we=0 immediately. A later write of 8'hC0 performs a full fresh transfer.
